// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the unified-memory arbiter: FSM state encodings,
// grant-owner encoding, MEM_LAT bounds and the counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    // Grant owner encoding; also used as the round-robin "last granted" pointer
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // Legal memory latency range and the counter width that covers it
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int CNT_W       = 4;

    // Out-of-range latencies are pulled into the legal range so the wait
    // counter can never wrap.
    function automatic int clamp_lat(input int lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, data port, memory-macro port and stall outputs of
// the unified-memory arbiter.
// Parameters: AW (address width), DW (data width).
// Modports:
//   slave  - the arbiter: takes requests and mem_rdata, drives acks, read
//            data, mem_* strobes and stalls.
//   master - the pipeline/memory side: the mirror image of slave.
// Signals:
//   if_req/if_addr -> if_rdata/if_ack          fetch request / completion
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ack   data request / completion
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata        memory macro
//   stall_if, stall_mem                                pipeline freeze
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
               mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
               mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
    );

endinterface

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select between the fetch and data requesters.
// Configuration macro: MEM_ARB_RR_EN
//   defined   - round-robin: with both requesting, grant the port that was
//               not granted last (last_own port is present).
//   undefined - fixed priority, data port over fetch (no last_own port).
// Ports:
//   if_req, dm_req  in  : pending requests
//   last_own        in  : owner of the previous grant (round-robin only)
//   any_req         out : at least one request pending
//   grant_own       out : winning owner (OWN_IF / OWN_DM)
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
`ifdef MEM_ARB_RR_EN
    input  logic last_own,
`endif
    output logic any_req,
    output logic grant_own
);

    assign any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_own = OWN_IF;
        if (if_req && dm_req) begin
            grant_own = (last_own == OWN_IF) ? OWN_DM : OWN_IF;
        end else if (dm_req) begin
            grant_own = OWN_DM;
        end
    end
`else
    // Data wins ties so the older instruction in MEM completes first
    assign grant_own = dm_req ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbiter and fixed-latency sequencer for the single-port unified memory
// shared by the IF and MEM pipeline stages. One access at a time walks
// IDLE -> ISSUE -> WAIT -> ACK; the owner gets a one-cycle ack with its read
// data, and each stage stalls while its request is outstanding.
// Configuration macro: MEM_ARB_RR_EN (round-robin instead of data-over-fetch
// priority; see mem_arb_pick).
// Parameters: MEM_LAT (1..15 read latency), AW, DW.
// Ports:
//   clk  in : clock, all state on the rising edge
//   rst  in : synchronous active-high reset
//   bus  slave modport of mem_arbiter_if (fetch port, data port, memory
//        macro port, stall outputs)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int             LAT      = clamp_lat(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             acc_we;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [DW-1:0]    mem_wdata_q;
    logic [DW-1:0]    if_rdata_q;
    logic [DW-1:0]    dm_rdata_q;
    logic             if_ack_q;
    logic             dm_ack_q;
    logic             any_req;
    logic             grant_own;

    // The owner register doubles as the round-robin pointer: it always holds
    // the most recent grant, and resets to "last granted fetch".
    mem_arb_pick u_pick (
        .if_req    (bus.if_req),
        .dm_req    (bus.dm_req),
`ifdef MEM_ARB_RR_EN
        .last_own  (owner),
`endif
        .any_req   (any_req),
        .grant_own (grant_own)
    );

    // Sequencer. The mem_* strobes are set on the grant edge so they are
    // high exactly during ISSUE; acks default low so they pulse for one
    // cycle. acc_we remembers a store after mem_we has dropped so the read
    // capture can be skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= OWN_IF;
            acc_we      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= grant_own;
                        mem_en_q <= 1'b1;
                        if (grant_own == OWN_DM) begin
                            mem_addr_q  <= bus.dm_addr;
                            mem_wdata_q <= bus.dm_wdata;
                            mem_we_q    <= bus.dm_we;
                            acc_we      <= bus.dm_we;
                        end else begin
                            mem_addr_q  <= bus.if_addr;
                            mem_we_q    <= 1'b0;
                            acc_we      <= 1'b0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    cnt      <= CNT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (owner == OWN_DM) begin
                            if (!acc_we) begin
                                dm_rdata_q <= bus.mem_rdata;
                            end
                            dm_ack_q <= 1'b1;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ack_q   <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;

    // Stalls release in the ack cycle so the stage can advance on that edge
    assign bus.stall_if  = bus.if_req & ~if_ack_q;
    assign bus.stall_mem = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A transaction-level model (request
// arrival, grant rule, fixed latency) predicts every grant, mem_en pulse, ack,
// stall and read value cycle by cycle. Honours MEM_ARB_RR_EN for the grant
// rule. Two extra instances with MEM_LAT=1 and MEM_LAT=15 cover the latency
// extremes.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus   ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus1  ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus15 ();

    mem_arbiter #(.MEM_LAT(LAT), .AW(AW), .DW(DW)) dut   (.clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.MEM_LAT(1),   .AW(AW), .DW(DW)) dut1  (.clk(clk), .rst(rst), .bus(bus1));
    mem_arbiter #(.MEM_LAT(15),  .AW(AW), .DW(DW)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

    // Memory images: dev_mem is written by the DUT's bus, ref_mem by the model
    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] dev_word(input logic [AW-1:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory macro models: read data is valid only in the single cycle
    // MEM_LAT cycles after the mem_en cycle; noise otherwise.
    int            cd0 = 0, cd1 = 0, cd15 = 0;
    logic [AW-1:0] ra0, ra1, ra15;

    always @(negedge clk) begin
        bus.mem_rdata   = DW'($urandom);
        bus1.mem_rdata  = DW'($urandom);
        bus15.mem_rdata = DW'($urandom);
        if (cd0 > 0) begin
            cd0--;
            if (cd0 == 0) bus.mem_rdata = dev_word(ra0);
        end
        if (cd1 > 0) begin
            cd1--;
            if (cd1 == 0) bus1.mem_rdata = dev_word(ra1);
        end
        if (cd15 > 0) begin
            cd15--;
            if (cd15 == 0) bus15.mem_rdata = dev_word(ra15);
        end
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) dev_mem[bus.mem_addr] = bus.mem_wdata;
            else begin cd0 = LAT; ra0 = bus.mem_addr; end
        end
        if (bus1.mem_en === 1'b1) begin cd1 = 1; ra1 = bus1.mem_addr; end
        if (bus15.mem_en === 1'b1) begin cd15 = 15; ra15 = bus15.mem_addr; end
    end

    // Model state, index 0 = fetch port, 1 = data port
    bit            act [2];
    bit            gnt [2];
    int            ack_at [2];
    logic [AW-1:0] p_addr [2];
    bit            p_we [2];
    logic [DW-1:0] p_wdata [2];
    logic [DW-1:0] exp_rd [2];
    int            obs_ack [2];
    int            model_last;

    // Scripted single requests for mode 0
    bit            sc_on [2];
    int            sc_at [2];
    bit            sc_we [2];
    logic [AW-1:0] sc_addr [2];
    logic [DW-1:0] sc_wdata [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_script(input int p, input bit on, input int at, input bit we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        sc_on[p] = on; sc_at[p] = at; sc_we[p] = we; sc_addr[p] = addr; sc_wdata[p] = wdata;
    endtask

    // Idle ports get noise on their address/data lines
    task automatic drive_port(input int p);
        if (p == 0) begin
            bus.if_req  = act[0];
            bus.if_addr = act[0] ? p_addr[0] : AW'($urandom);
        end else begin
            bus.dm_req   = act[1];
            bus.dm_we    = act[1] ? p_we[1] : 1'($urandom);
            bus.dm_addr  = act[1] ? p_addr[1] : AW'($urandom);
            bus.dm_wdata = act[1] ? p_wdata[1] : DW'($urandom);
        end
    endtask

    // Traffic engine. mode 0: scripted, 1: random, 2: continuous.
    // New requests only before stop_new; then runs until both ports drain.
    task automatic run_traffic(input string tag, input int mode, input int stop_new, input int max_cyc);
        int            free_at;
        int            en_at;
        int            w;
        bit            go;
        bit            exp_ack;
        bit            exp_stall;
        logic          o_ack;
        logic          o_stall;
        logic [DW-1:0] o_rd;
        logic [AW-1:0] e_addr;
        bit            e_we;
        logic [DW-1:0] e_wdata;
        free_at = 0;
        en_at   = -1;
        e_addr  = '0;
        e_we    = 1'b0;
        e_wdata = '0;
        obs_ack[0] = -1;
        obs_ack[1] = -1;
        for (int c = 0; c < max_cyc; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (act[p] && gnt[p] && ack_at[p] == c - 1) act[p] = 1'b0;
                if (!act[p] && c < stop_new) begin
                    case (mode)
                        0:       go = sc_on[p] && (sc_at[p] == c);
                        1:       go = ($urandom_range(0, 2) == 0);
                        default: go = 1'b1;
                    endcase
                    if (go) begin
                        act[p] = 1'b1;
                        gnt[p] = 1'b0;
                        if (mode == 0) begin
                            p_addr[p] = sc_addr[p]; p_we[p] = sc_we[p]; p_wdata[p] = sc_wdata[p];
                        end else begin
                            p_addr[p]  = AW'(32'h300 + 4 * $urandom_range(0, 15));
                            p_we[p]    = (p == 1) && ($urandom_range(0, 2) == 0);
                            p_wdata[p] = DW'($urandom);
                        end
                    end
                end
                drive_port(p);
            end
            // One access per MEM_LAT+3 cycles, granted only when the arbiter is idle
            if (c >= free_at) begin
                w = -1;
                if (act[0] && !gnt[0] && act[1] && !gnt[1]) begin
`ifdef MEM_ARB_RR_EN
                    w = (model_last == 0) ? 1 : 0;
`else
                    w = 1;
`endif
                end else if (act[1] && !gnt[1]) begin
                    w = 1;
                end else if (act[0] && !gnt[0]) begin
                    w = 0;
                end
                if (w >= 0) begin
                    gnt[w]     = 1'b1;
                    ack_at[w]  = c + LAT + 2;
                    free_at    = c + LAT + 3;
                    en_at      = c + 1;
                    e_addr     = p_addr[w];
                    e_we       = p_we[w];
                    e_wdata    = p_wdata[w];
                    model_last = w;
                    if (p_we[w]) ref_mem[p_addr[w]] = p_wdata[w];
                    else         exp_rd[w] = ref_word(p_addr[w]);
                end
            end
            @(negedge clk);
            checks++;
            if (bus.mem_en !== (c == en_at)) begin
                failures++;
                $display("[TB] FAIL %s mem_en c=%0d: got %b expected %b", tag, c, bus.mem_en, (c == en_at));
            end
            if (c == en_at) begin
                checks++;
                if (bus.mem_addr !== e_addr) begin
                    failures++;
                    $display("[TB] FAIL %s mem_addr c=%0d: got %h expected %h", tag, c, bus.mem_addr, e_addr);
                end
                checks++;
                if (bus.mem_we !== e_we) begin
                    failures++;
                    $display("[TB] FAIL %s mem_we c=%0d: got %b expected %b", tag, c, bus.mem_we, e_we);
                end
                if (e_we) begin
                    checks++;
                    if (bus.mem_wdata !== e_wdata) begin
                        failures++;
                        $display("[TB] FAIL %s mem_wdata c=%0d: got %h expected %h", tag, c, bus.mem_wdata, e_wdata);
                    end
                end
            end else begin
                checks++;
                if (bus.mem_we !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL %s mem_we_idle c=%0d: got %b expected 0", tag, c, bus.mem_we);
                end
            end
            for (int p = 0; p < 2; p++) begin
                exp_ack   = act[p] && gnt[p] && (ack_at[p] == c);
                exp_stall = act[p] && !exp_ack;
                o_ack     = (p == 1) ? bus.dm_ack : bus.if_ack;
                o_stall   = (p == 1) ? bus.stall_mem : bus.stall_if;
                o_rd      = (p == 1) ? bus.dm_rdata : bus.if_rdata;
                if (o_ack === 1'b1) obs_ack[p] = c;
                checks++;
                if (o_ack !== exp_ack) begin
                    failures++;
                    $display("[TB] FAIL %s ack%0d c=%0d: got %b expected %b", tag, p, c, o_ack, exp_ack);
                end
                checks++;
                if (o_stall !== exp_stall) begin
                    failures++;
                    $display("[TB] FAIL %s stall%0d c=%0d: got %b expected %b", tag, p, c, o_stall, exp_stall);
                end
                if (exp_ack) begin
                    checks++;
                    if (o_rd !== exp_rd[p]) begin
                        failures++;
                        $display("[TB] FAIL %s rdata%0d c=%0d: got %h expected %h", tag, p, c, o_rd, exp_rd[p]);
                    end
                end
            end
            if (c >= stop_new && !act[0] && !act[1]) break;
        end
        checks++;
        if ((act[0] || act[1]) !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s drain: got pending=%b%b expected 00", tag, act[1], act[0]);
        end
        act[0] = 1'b0;
        act[1] = 1'b0;
        drive_port(0);
        drive_port(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        act[0] = 1'b0; act[1] = 1'b0;
        drive_port(0);
        drive_port(1);
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset strobes: got %b expected 0000", {bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack});
        end
        checks++;
        if (bus.mem_addr !== '0) begin
            failures++;
            $display("[TB] FAIL reset mem_addr: got %h expected 0", bus.mem_addr);
        end
        checks++;
        if (bus.mem_wdata !== '0) begin
            failures++;
            $display("[TB] FAIL reset mem_wdata: got %h expected 0", bus.mem_wdata);
        end
        checks++;
        if ({bus.if_rdata, bus.dm_rdata} !== '0) begin
            failures++;
            $display("[TB] FAIL reset rdata: got %h/%h expected 0", bus.if_rdata, bus.dm_rdata);
        end
        checks++;
        if ({bus1.mem_en, bus15.mem_en, bus1.if_ack, bus15.if_ack} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset sweep_duts: got %b expected 0000", {bus1.mem_en, bus15.mem_en, bus1.if_ack, bus15.if_ack});
        end
        tick();
        rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        model_last = 0;
    endtask

    task automatic test_single_fetch();
        dev_mem[32'h40] = 32'h2402_0005;
        ref_mem[32'h40] = 32'h2402_0005;
        set_script(0, 1'b1, 0, 1'b0, 32'h40, '0);
        set_script(1, 1'b0, 0, 1'b0, '0, '0);
        run_traffic("single_fetch", 0, 1, 20);
        checks++;
        if (obs_ack[0] !== 4) begin
            failures++;
            $display("[TB] FAIL single_fetch ack_cycle: got %0d expected 4", obs_ack[0]);
        end
    endtask

    task automatic test_store_load();
        set_script(0, 1'b0, 0, 1'b0, '0, '0);
        set_script(1, 1'b1, 0, 1'b1, 32'h200, 32'hDEAD_BEEF);
        run_traffic("store", 0, 1, 20);
        checks++;
        if (obs_ack[1] !== 4) begin
            failures++;
            $display("[TB] FAIL store ack_cycle: got %0d expected 4", obs_ack[1]);
        end
        set_script(1, 1'b1, 0, 1'b0, 32'h200, '0);
        run_traffic("load_back", 0, 1, 20);
        checks++;
        if (bus.dm_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL load_back value: got %h expected deadbeef", bus.dm_rdata);
        end
    endtask

    task automatic test_both_requests();
        set_script(0, 1'b1, 0, 1'b0, 32'h44, '0);
        set_script(1, 1'b1, 0, 1'b0, 32'h100, '0);
        run_traffic("both", 0, 1, 30);
`ifndef MEM_ARB_RR_EN
        checks++;
        if ({obs_ack[1], obs_ack[0]} !== {32'sd4, 32'sd9}) begin
            failures++;
            $display("[TB] FAIL both ack_cycles: got dm=%0d if=%0d expected dm=4 if=9", obs_ack[1], obs_ack[0]);
        end
`endif
    endtask

    task automatic test_continuous();
        run_traffic("continuous", 2, 40, 150);
    endtask

    task automatic test_random();
        run_traffic("random_a", 1, 300, 700);
        run_traffic("random_b", 1, 300, 700);
    endtask

    task automatic test_reset_mid_access();
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h60;
        bus.dm_req  = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) tick();
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            if (c == 8) bus.if_req = 1'b0;
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if ({bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack} !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL rst_mid strobes: got %b expected 0000", {bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack});
                end
                checks++;
                if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata} !== '0) begin
                    failures++;
                    $display("[TB] FAIL rst_mid regs: got %h %h %h %h expected 0", bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata);
                end
                checks++;
                if (bus.stall_if !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL rst_mid stall_if: got %b expected 1", bus.stall_if);
                end
            end
            if (c >= 1) begin
                checks++;
                if (bus.mem_en !== (c == 1 || c == 4)) begin
                    failures++;
                    $display("[TB] FAIL rst_mid mem_en c=%0d: got %b expected %b", c, bus.mem_en, (c == 1 || c == 4));
                end
                checks++;
                if (bus.if_ack !== (c == 7)) begin
                    failures++;
                    $display("[TB] FAIL rst_mid if_ack c=%0d: got %b expected %b", c, bus.if_ack, (c == 7));
                end
            end
            if (c == 7) begin
                checks++;
                if (bus.if_rdata !== ref_word(32'h60)) begin
                    failures++;
                    $display("[TB] FAIL rst_mid if_rdata: got %h expected %h", bus.if_rdata, ref_word(32'h60));
                end
            end
        end
        exp_rd[0] = ref_word(32'h60);
        exp_rd[1] = '0;
        model_last = 0;
    endtask

    task automatic test_latency_sweep();
        int            lat;
        int            ack_k;
        logic [AW-1:0] addr;
        logic [DW-1:0] rd;
        logic          a;
        logic [DW-1:0] r;
        for (int s = 0; s < 2; s++) begin
            lat   = (s == 0) ? 1 : 15;
            addr  = AW'(32'h500 + 4 * s);
            ack_k = -1;
            rd    = '0;
            tick();
            if (s == 0) begin bus1.if_req = 1'b1; bus1.if_addr = addr; end
            else        begin bus15.if_req = 1'b1; bus15.if_addr = addr; end
            for (int k = 0; k <= lat + 5 && ack_k < 0; k++) begin
                @(negedge clk);
                a = (s == 0) ? bus1.if_ack : bus15.if_ack;
                r = (s == 0) ? bus1.if_rdata : bus15.if_rdata;
                if (a === 1'b1) begin ack_k = k; rd = r; end
                tick();
            end
            bus1.if_req  = 1'b0;
            bus15.if_req = 1'b0;
            checks++;
            if (ack_k !== lat + 2) begin
                failures++;
                $display("[TB] FAIL sweep lat=%0d ack_cycle: got %0d expected %0d", lat, ack_k, lat + 2);
            end
            checks++;
            if (rd !== ref_word(addr)) begin
                failures++;
                $display("[TB] FAIL sweep lat=%0d rdata: got %h expected %h", lat, rd, ref_word(addr));
            end
            repeat (3) tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.dm_req = 1'b0; bus1.dm_we = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
        bus15.if_req = 1'b0; bus15.if_addr = '0;
        bus15.dm_req = 1'b0; bus15.dm_we = 1'b0; bus15.dm_addr = '0; bus15.dm_wdata = '0;
        model_last = 0;

        test_reset();
        test_single_fetch();
        test_store_load();
        test_both_requests();
        test_continuous();
        test_reset_mid_access();
        test_random();
        test_latency_sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
